// File: rtl/clarke_park_pkg.sv
// rtl/clarke_park_pkg.sv - shared FOC constants and conversion state encoding
package clarke_park_pkg;

  localparam int Q15_W         = 16;
  localparam int ACC_W         = 33;
  localparam int INV_SQRT3_Q15 = 18919;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAP,
    S_CLK,
    S_P1,
    S_P2,
    S_P3,
    S_P4,
    S_OUT
  } cp_state_t;

endpackage

// File: rtl/clarke_park_if.sv
// rtl/clarke_park_if.sv - start/operand/result bundle of the Clarke-Park converter
interface clarke_park_if;
  import clarke_park_pkg::*;

  logic                    iCP_en;
  logic signed [Q15_W-1:0] iIa;
  logic signed [Q15_W-1:0] iIb;
  logic signed [Q15_W-1:0] iSin;
  logic signed [Q15_W-1:0] iCos;
  logic                    oCP_done;
  logic signed [Q15_W-1:0] oId;
  logic signed [Q15_W-1:0] oIq;
  logic                    oSat;
  logic                    oBusy;

  modport master (
    output iCP_en, iIa, iIb, iSin, iCos,
    input  oCP_done, oId, oIq, oSat, oBusy
  );

  modport slave (
    input  iCP_en, iIa, iIb, iSin, iCos,
    output oCP_done, oId, oIq, oSat, oBusy
  );

endinterface

// File: rtl/sat_s16.sv
// rtl/sat_s16.sv - clamp a signed value of any width into signed 16 bits
module sat_s16 #(
  parameter int IN_W = 18
) (
  input  logic signed [IN_W-1:0] din,
  output logic signed [15:0]     dout,
  output logic                   sat
);

  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(32767);
  localparam logic signed [IN_W-1:0] MIN_V = IN_W'(-32768);

  always_comb begin
    dout = din[15:0];
    sat  = 1'b0;
    if (din > MAX_V) begin
      dout = 16'sh7fff;
      sat  = 1'b1;
    end else if (din < MIN_V) begin
      dout = 16'sh8000;
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/clarke_park.sv
// rtl/clarke_park.sv - Clarke then Park transform, one shared multiplier over four cycles
module clarke_park
  import clarke_park_pkg::*;
(
  input logic          iClk,
  input logic          iRst,
  clarke_park_if.slave cp
);

  localparam logic signed [33:0] K34 = 34'(INV_SQRT3_Q15);

  cp_state_t state, state_nxt;

  logic                    en_prev;
  logic                    start;
  logic signed [Q15_W-1:0] ia_q, ib_q, sin_q, cos_q, ibeta_q;
  logic                    beta_sat_q;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [Q15_W-1:0] id_q, iq_q;
  logic                    sat_q;

  logic signed [17:0]      clarke_sum;
  logic signed [33:0]      clarke_prod, clarke_sh;
  logic signed [Q15_W-1:0] ibeta_w, id_w, iq_w;
  logic                    beta_sat_w, d_sat_w, q_sat_w;
  logic signed [Q15_W-1:0] mul_a, mul_b;
  logic signed [31:0]      mul_p;
  logic signed [ACC_W-1:0] mul_ext, acc_d_sh, acc_q_sh;

  assign start = cp.iCP_en & ~en_prev;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_CAP;
      S_CAP:  state_nxt = S_CLK;
      S_CLK:  state_nxt = S_P1;
      S_P1:   state_nxt = S_P2;
      S_P2:   state_nxt = S_P3;
      S_P3:   state_nxt = S_P4;
      S_P4:   state_nxt = S_OUT;
      S_OUT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results appear combinationally in OUT and are held in registers afterwards
  always_comb begin
    cp.oCP_done = (state == S_OUT);
    cp.oBusy    = (state != S_IDLE);
    cp.oId      = (state == S_OUT) ? id_w : id_q;
    cp.oIq      = (state == S_OUT) ? iq_w : iq_q;
    cp.oSat     = (state == S_OUT) ? (beta_sat_q | d_sat_w | q_sat_w) : sat_q;
  end

  assign clarke_sum  = {{2{ia_q[15]}}, ia_q} + {ib_q[15], ib_q, 1'b0};
  assign clarke_prod = $signed({{16{clarke_sum[17]}}, clarke_sum}) * K34;
  assign clarke_sh   = clarke_prod >>> 15;

  sat_s16 #(.IN_W(34)) u_sat_beta (.din(clarke_sh), .dout(ibeta_w), .sat(beta_sat_w));

  always_comb begin
    mul_a = ia_q;
    mul_b = cos_q;
    case (state)
      S_P2: begin mul_a = ibeta_q; mul_b = sin_q; end
      S_P3: begin mul_a = ibeta_q; mul_b = cos_q; end
      S_P4: begin mul_a = ia_q;    mul_b = sin_q; end
      default: ;
    endcase
  end

  assign mul_p   = $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});
  assign mul_ext = {mul_p[31], mul_p};

  assign acc_d_sh = acc_d >>> 15;
  assign acc_q_sh = acc_q >>> 15;

  sat_s16 #(.IN_W(ACC_W)) u_sat_d (.din(acc_d_sh), .dout(id_w), .sat(d_sat_w));
  sat_s16 #(.IN_W(ACC_W)) u_sat_q (.din(acc_q_sh), .dout(iq_w), .sat(q_sat_w));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      en_prev    <= 1'b0;
      ia_q       <= '0;
      ib_q       <= '0;
      sin_q      <= '0;
      cos_q      <= '0;
      ibeta_q    <= '0;
      beta_sat_q <= 1'b0;
      acc_d      <= '0;
      acc_q      <= '0;
      id_q       <= '0;
      iq_q       <= '0;
      sat_q      <= 1'b0;
    end else begin
      en_prev <= cp.iCP_en;
      case (state)
        S_IDLE: if (start) begin
          ia_q  <= cp.iIa;
          ib_q  <= cp.iIb;
          sin_q <= cp.iSin;
          cos_q <= cp.iCos;
        end
        S_CLK: begin
          ibeta_q    <= ibeta_w;
          beta_sat_q <= beta_sat_w;
        end
        S_P1: acc_d <= mul_ext;
        S_P2: acc_d <= acc_d + mul_ext;
        S_P3: acc_q <= mul_ext;
        S_P4: acc_q <= acc_q - mul_ext;
        S_OUT: begin
          id_q  <= id_w;
          iq_q  <= iq_w;
          sat_q <= beta_sat_q | d_sat_w | q_sat_w;
        end
        default: ;
      endcase
    end
  end

endmodule
